// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader: LOAD assembles little-endian
// words from rx_data, RUN answers the core's PC combinationally.
module imem_loader #(
    parameter int          DEPTH  = 256,
    parameter int          ADDR_W = 8,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_done,
    input  logic [31:0]       PC,
    output logic [31:0]       instr,
    output logic              core_hold,
    output logic              misaligned,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;
    localparam logic [ADDR_W:0]   COUNT_TOP = (ADDR_W+1)'(DEPTH - 1);

    logic [0:0]        state_reg, state_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [ADDR_W-1:0] word_addr_reg, word_addr_next;
    logic [ADDR_W:0]   word_count_reg, word_count_next;
    logic [23:0]       shift_reg, shift_next;

    logic [31:0] mem [DEPTH];

    logic        in_load;
    logic        accept;
    logic        full_word;
    logic        flush;
    logic        wr_en;
    logic        last_word;
    logic [31:0] word_asm;

    assign in_load   = (state_reg == S_LOAD);
    assign accept    = in_load && rx_valid;
    assign full_word = accept && (byte_cnt_reg == 2'd3);
    assign flush     = in_load && load_done && ((byte_cnt_reg != 2'd0) || accept);
    assign wr_en     = full_word || flush;
    assign last_word = (word_count_reg == COUNT_TOP);

    // Byte lane k takes the incoming byte when it is the k-th of the word; lanes not
    // yet received read as zero so a flushed partial word has clean upper bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_stored
                assign word_asm[8*gi +: 8] = (accept && (byte_cnt_reg == 2'(gi)))
                                             ? rx_data : shift_reg[8*gi +: 8];
            end else begin : g_top
                assign word_asm[8*gi +: 8] = (accept && (byte_cnt_reg == 2'(gi)))
                                             ? rx_data : 8'h00;
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        byte_cnt_next   = byte_cnt_reg;
        word_addr_next  = word_addr_reg;
        word_count_next = word_count_reg;
        shift_next      = shift_reg;
        if (wr_en) begin
            byte_cnt_next   = 2'd0;
            shift_next      = 24'h0;
            word_count_next = word_count_reg + COUNT_ONE;
            word_addr_next  = last_word ? word_addr_reg : word_addr_reg + ADDR_ONE;
        end else if (accept) begin
            byte_cnt_next = byte_cnt_reg + 2'd1;
            shift_next    = word_asm[23:0];
        end
        if (in_load && (load_done || (wr_en && last_word))) begin
            state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_LOAD;
            byte_cnt_reg   <= 2'd0;
            word_addr_reg  <= '0;
            word_count_reg <= '0;
            shift_reg      <= 24'h0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            word_addr_reg  <= word_addr_next;
            word_count_reg <= word_count_next;
            shift_reg      <= shift_next;
        end
    end

    // The array is never cleared; word_count masks stale words on the read side.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[word_addr_reg] <= word_asm;
        end
    end

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              hit;

    assign idx        = PC[ADDR_W+1:2];
    assign in_range   = (PC[31:ADDR_W+2] == '0);
    assign hit        = !in_load && (PC[1:0] == 2'b00) && in_range
                        && ({1'b0, idx} < word_count_reg);
    assign instr      = hit ? mem[idx] : NOP;
    assign misaligned = !in_load && (PC[1:0] != 2'b00);
    assign rx_ready   = in_load;
    assign core_hold  = in_load;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed checks for imem_loader: reset state, loads, flushes, full-depth stream,
// fetch table, mid-load reset and RUN-phase input immunity.
module tb_imem_loader;

    localparam int          DEPTH  = 256;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              load_done;
    logic [31:0]       PC;
    logic [31:0]       instr;
    logic              core_hold;
    logic              misaligned;
    logic [ADDR_W:0]   word_count;

    int total = 0;
    int bad   = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .load_done  (load_done),
        .PC         (PC),
        .instr      (instr),
        .core_hold  (core_hold),
        .misaligned (misaligned),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_instr;
        logic        exp_mis;
    } fvec_t;

    fvec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        rx_valid  = 1'b0;
        load_done = 1'b0;
        clk_step();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        clk_step();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        clk_step();
        load_done = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        #1;
        check(name, instr, exp);
    endtask

    function automatic logic [7:0] sbyte(input int i);
        return 8'((i * 7) + (i >> 8));
    endfunction

    function automatic logic [31:0] sword(input int w);
        return {sbyte(4*w+3), sbyte(4*w+2), sbyte(4*w+1), sbyte(4*w)};
    endfunction

    initial begin
        logic [7:0] prog [12];
        logic [7:0] tail [4];
        logic       rdy_ok;
        prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00,
                 8'h33, 8'h06, 8'hB5, 8'h00};
        tail = '{8'h11, 8'h22, 8'h33, 8'h44};
        tbl[0] = '{32'd0,          32'h00A00513, 1'b0};
        tbl[1] = '{32'd4,          32'h00B00593, 1'b0};
        tbl[2] = '{32'd8,          32'h00B50633, 1'b0};
        tbl[3] = '{32'd12,         NOP,          1'b0};
        tbl[4] = '{32'd2,          NOP,          1'b1};
        tbl[5] = '{32'd5,          NOP,          1'b1};
        tbl[6] = '{32'(4*DEPTH),   NOP,          1'b0};
        tbl[7] = '{32'(4*DEPTH-4), NOP,          1'b0};
        tbl[8] = '{32'h80000000,   NOP,          1'b0};

        rx_data = 8'h00;
        PC      = 32'd0;
        do_reset();

        check("reset rx_ready",   32'(rx_ready),   32'd1);
        check("reset core_hold",  32'(core_hold),  32'd1);
        check("reset instr",      instr,           NOP);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset word_count", 32'(word_count), 32'd0);

        // Three-word program; fetch must stay NOP while still loading
        for (int i = 0; i < 12; i++) begin
            send_byte(prog[i]);
            if (i == 7) begin
                fetch("load-phase fetch", 32'd0, NOP);
                check("load-phase hold", 32'(core_hold), 32'd1);
            end
        end
        pulse_done();
        check("prog word_count", 32'(word_count), 32'd3);
        check("prog core_hold",  32'(core_hold),  32'd0);
        check("prog rx_ready",   32'(rx_ready),   32'd0);
        for (int i = 0; i < 9; i++) begin
            PC = tbl[i].pc;
            #1;
            check($sformatf("tbl[%0d] instr pc=%08h", i, tbl[i].pc), instr, tbl[i].exp_instr);
            check($sformatf("tbl[%0d] mis pc=%08h", i, tbl[i].pc), 32'(misaligned), 32'(tbl[i].exp_mis));
        end

        // Partial word flush; stale mem[1] must read as NOP
        do_reset();
        send_byte(8'hEF);
        send_byte(8'hBE);
        pulse_done();
        check("partial word_count", 32'(word_count), 32'd1);
        fetch("partial pc0", 32'd0, 32'h0000BEEF);
        fetch("stale pc4",   32'd4, NOP);

        // Byte accepted in the same cycle as load_done is included
        do_reset();
        send_byte(8'hAA);
        rx_data   = 8'hBB;
        rx_valid  = 1'b1;
        load_done = 1'b1;
        clk_step();
        rx_valid  = 1'b0;
        load_done = 1'b0;
        check("same-cycle word_count", 32'(word_count), 32'd1);
        fetch("same-cycle pc0", 32'd0, 32'h0000BBAA);

        // load_done with nothing pending writes nothing
        do_reset();
        pulse_done();
        check("empty word_count", 32'(word_count), 32'd0);
        check("empty core_hold",  32'(core_hold),  32'd0);
        fetch("empty pc0", 32'd0, NOP);

        // Full-depth stream with rx_valid held high, no load_done
        do_reset();
        rdy_ok   = 1'b1;
        rx_valid = 1'b1;
        for (int i = 0; i < 4*DEPTH; i++) begin
            if (rx_ready !== 1'b1) rdy_ok = 1'b0;
            rx_data = sbyte(i);
            clk_step();
        end
        check("stream rx_ready during load", 32'(rdy_ok), 32'd1);
        check("stream rx_ready after last", 32'(rx_ready), 32'd0);
        check("stream core_hold", 32'(core_hold), 32'd0);
        rx_data = 8'h5A;
        clk_step();
        rx_valid = 1'b0;
        check("stream word_count", 32'(word_count), 32'(DEPTH));
        fetch("stream last word",  32'(4*DEPTH-4), sword(DEPTH-1));
        fetch("stream first word", 32'd0, sword(0));
        fetch("stream mid word",   32'd512, sword(128));
        fetch("stream beyond",     32'(4*DEPTH), NOP);

        // Reset mid-load discards the partial word
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(tail[i]);
        pulse_done();
        check("midreset word_count", 32'(word_count), 32'd1);
        fetch("midreset pc0", 32'd0, 32'h44332211);
        fetch("midreset pc4", 32'd4, NOP);

        // RUN ignores the byte stream and load_done
        rdy_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_valid  = 1'b1;
            rx_data   = 8'($urandom);
            load_done = 1'($urandom_range(0, 1));
            if (rx_ready !== 1'b0) rdy_ok = 1'b0;
            clk_step();
        end
        rx_valid  = 1'b0;
        load_done = 1'b0;
        check("run rx_ready low", 32'(rdy_ok), 32'd1);
        check("run word_count kept", 32'(word_count), 32'd1);
        fetch("run pc0 kept", 32'd0, 32'h44332211);
        fetch("run pc4 kept", 32'd4, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
